mux_arb_nch: RTL and testbench
==============================

# mux_arb_nch

Parametrised N-channel, W-bit arbitrating multiplexer with a registered output stage and valid/ready handshakes on every channel. It is the successor to the fixed 4:1 16-bit select mux. Instead of an external select, it chooses among requesting channels by fixed priority or round-robin, and it holds the selected word until the consumer accepts it. It sits between multiple operand/result producers (ALU, load unit, immediate path) and a single shared bus or writeback port.

## Interface
- WIDTH, 16, data width per channel (1..64)
- NCH, 4, number of input channels (power of two, 2..16)
- SELW, $clog2(NCH), width of channel index (derived; do not override)

- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- in_valid  in  NCH  bit i = channel i presents a word
- in_data  in  NCH*WIDTH  channel i word at bits [i*WIDTH +: WIDTH]
- in_ready  out  NCH  bit i = channel i word accepted this cycle (one-hot or zero)
- mode  in  1  0 = fixed priority (lowest index wins), 1 = round-robin
- out_valid  out  1  output register holds a word
- out_data  out  WIDTH  selected word
- out_chan  out  SELW  index of the channel that supplied out_data
- out_ready  in  1  consumer accepts out_data this cycle

## Operation
- Reset: one clock, synchronous and active-high; the reset values are:
  - out_valid=0
  - out_data=0
  - out_chan=0
  - round-robin pointer last=NCH-1, so channel 0 has top RR priority after reset.
- can_accept = !out_valid || out_ready (single-entry output register; full throughput, no bubble).
- Grant (combinational, one-hot or zero):
  - mode=0: lowest i with in_valid[i].
  - mode=1: first i with in_valid[i], searching from last+1 upward and wrapping modulo NCH. Channel "last" has the lowest priority.
- in_ready = grant & {NCH{can_accept}}. in_ready never asserts for a channel whose in_valid is 0.
- Transfer into the block happens when any in_ready bit is 1. On that edge:
  - out_data <= selected word
  - out_chan <= grant index
  - out_valid <= 1
  - last <= grant index. last updates in both modes, so switching to RR continues fairly.
- If out_ready=1 and there is no transfer in: out_valid <= 0. out_data and out_chan hold their old values; they are don't-care but must not X.
- While out_valid=1 and out_ready=0, out_data, out_chan and out_valid are frozen and all in_ready=0.
- Producers must hold in_valid/in_data until accepted. The block must not rely on this; it samples only on a transfer.
- mode is sampled every cycle. A change affects the next grant only, never a held word.
- Reset mid-operation: any held word is discarded, out_valid=0 on the next cycle, last=NCH-1.

## Timing
- Latency: 1 cycle from accepted input to out_valid.
- Throughput: 1 word/cycle sustained while out_ready=1.
- in_ready depends combinationally on in_valid, mode, last, out_valid and out_ready. There is no combinational path from in_data to any output.
- out_valid, out_data and out_chan are registered outputs.
- Simultaneous consume and accept in the same cycle: the new word replaces the old one, and out_valid stays 1.
- Fairness: in RR mode with all NCH channels continuously valid and out_ready=1, each channel is granted exactly once in every NCH consecutive grants.

## Test plan
- Reset/idle:
  - stimulus: assert rst 2 cycles with in_valid=4'b1111.
  - required: out_valid=0, out_data=0, out_chan=0 and in_ready=0 while rst is high.
  - after rst falls with mode=1: the first grant goes to ch0.
- Fixed priority:
  - stimulus: mode=0, NCH=4, in_valid=4'b1010, data ch1=16'h1111, ch3=16'h3333, out_ready=1.
  - required: in_ready=4'b0010; next cycle out_data=16'h1111, out_chan=1.
  - ch1 stays valid, so ch3 is never granted.
- Round-robin:
  - stimulus: mode=1, all four channels valid (data 16'hA000+i), out_ready=1 for 8 cycles.
  - required: out_chan sequence is 0,1,2,3,0,1,2,3 with back-to-back out_valid=1.
- Backpressure:
  - stimulus: hold out_ready=0 for 3 cycles after out_data=16'hBEEF.
  - required: out_data stays 16'hBEEF and in_ready=0 throughout.
  - when out_ready rises, a new word is accepted in that same cycle and out_valid never drops.
- Mode switch and wrap:
  - stimulus: mode=1, last=3, in_valid=4'b1001; then switch to mode=0 with in_valid=4'b1001.
  - required: the RR grant is ch0 (wrap from 3 to 0).
  - after the switch, the grant is ch0 under fixed priority; with in_valid=4'b1000 the grant is ch3.
- Reset mid-transfer:
  - stimulus: assert rst while out_valid=1 and out_ready=0.
  - required: the next cycle has out_valid=0 and out_data=0.
  - the word is not delivered, and the RR order restarts at ch0.

Source files
------------

// File: rtl/mux_arb_nch.sv
// N-channel, W-bit arbitrating multiplexer with a single-entry registered output.
// Picks one requesting channel per cycle by fixed priority or round-robin and
// holds the selected word until the consumer takes it.
module mux_arb_nch #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NCH   = 4,
  parameter int unsigned SELW  = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH-1:0]       in_valid,
  input  logic [NCH*WIDTH-1:0] in_data,
  output logic [NCH-1:0]       in_ready,
  input  logic                 mode,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_chan,
  input  logic                 out_ready
);

  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic [SELW-1:0]  out_chan_q;
  logic [SELW-1:0]  last_q;

  logic             gnt_found;
  logic [SELW-1:0]  gnt_idx;
  logic [SELW-1:0]  cand;
  logic [WIDTH-1:0] sel_data;
  logic             can_accept;
  logic             xfer;

  // Arbitration: find the winning channel index for the current mode.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    if (!mode) begin
      // Scan downward so the lowest valid index is the final assignment.
      for (int i = NCH - 1; i >= 0; i--) begin
        if (in_valid[i]) begin
          gnt_found = 1'b1;
          gnt_idx   = SELW'(i);
        end
      end
    end else begin
      // Offsets NCH..1 from last; offset NCH wraps to last itself (lowest
      // priority), and the smallest offset ends up winning.
      for (int k = NCH; k >= 1; k--) begin
        cand = last_q + SELW'(k);
        if (in_valid[cand]) begin
          gnt_found = 1'b1;
          gnt_idx   = cand;
        end
      end
    end
  end

  // Word select driven only by the grant index, so in_data never reaches an output.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NCH; i++) begin
      if (gnt_idx == SELW'(i)) begin
        sel_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Handshake: accept when the output slot is free or being drained; never in reset.
  always_comb begin
    can_accept = (!out_valid_q || out_ready) && !rst;
    in_ready   = '0;
    if (gnt_found && can_accept) begin
      in_ready = NCH'(1) << gnt_idx;
    end
    xfer = |in_ready;
  end

  // Output register and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
      last_q      <= SELW'(NCH - 1);
    end else if (xfer) begin
      out_valid_q <= 1'b1;
      out_data_q  <= sel_data;
      out_chan_q  <= gnt_idx;
      last_q      <= gnt_idx;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;

endmodule

// File: tb/tb_mux_arb_nch.sv
// Directed self-checking bench for mux_arb_nch (NCH=4, WIDTH=16).
module tb_mux_arb_nch;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned NCH   = 4;
  localparam int unsigned SELW  = 2;

  logic                 clk;
  logic                 rst;
  logic [NCH-1:0]       in_valid;
  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0]       in_ready;
  logic                 mode;
  logic                 out_valid;
  logic [WIDTH-1:0]     out_data;
  logic [SELW-1:0]      out_chan;
  logic                 out_ready;

  int checks = 0;
  int errors = 0;

  mux_arb_nch #(
    .WIDTH(WIDTH),
    .NCH  (NCH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .mode     (mode),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_chan (out_chan),
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int ch, input logic [WIDTH-1:0] v);
    in_data[ch*WIDTH +: WIDTH] = v;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [15:0] d,
                           input logic [1:0] c);
    check({tag, "_valid"}, 32'(out_valid), 32'(v));
    check({tag, "_data"},  32'(out_data),  32'(d));
    check({tag, "_chan"},  32'(out_chan),  32'(c));
  endtask

  initial begin
    rst       = 1'b1;
    mode      = 1'b1;
    out_ready = 1'b1;
    in_valid  = 4'b1111;
    in_data   = '0;
    for (int i = 0; i < NCH; i++) set_data(i, 16'hA000 + 16'(i));

    // Reset / idle
    tick();
    tick();
    check_out("rst", 1'b0, 16'h0000, 2'd0);
    check("rst_in_ready", 32'(in_ready), 32'h0);

    // Round-robin from reset: 0,1,2,3,0,1,2,3 back-to-back
    rst = 1'b0;
    #1;
    check("rr_first_ready", 32'(in_ready), 32'b0001);
    for (int k = 0; k < 8; k++) begin
      tick();
      check_out($sformatf("rr%0d", k), 1'b1, 16'hA000 + 16'(k % 4), 2'(k % 4));
    end

    // Fixed priority: ch1 beats ch3 repeatedly
    mode     = 1'b0;
    in_valid = 4'b1010;
    set_data(1, 16'h1111);
    set_data(3, 16'h3333);
    #1;
    check("fp_ready", 32'(in_ready), 32'b0010);
    tick();
    check_out("fp0", 1'b1, 16'h1111, 2'd1);
    tick();
    check_out("fp1", 1'b1, 16'h1111, 2'd1);

    // Backpressure on 16'hBEEF
    in_valid = 4'b0001;
    set_data(0, 16'hBEEF);
    tick();
    check_out("bp_load", 1'b1, 16'hBEEF, 2'd0);
    out_ready = 1'b0;
    in_valid  = 4'b0010;
    set_data(1, 16'h2222);
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("bp_ready%0d", k), 32'(in_ready), 32'h0);
      tick();
      check_out($sformatf("bp_hold%0d", k), 1'b1, 16'hBEEF, 2'd0);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(in_ready), 32'b0010);
    tick();
    check_out("bp_release", 1'b1, 16'h2222, 2'd1);

    // Fixed priority single ch3, sets last=3
    in_valid = 4'b1000;
    #1;
    check("fp_ch3_ready", 32'(in_ready), 32'b1000);
    tick();
    check_out("fp_ch3", 1'b1, 16'h3333, 2'd3);

    // RR wrap from last=3 to ch0
    mode     = 1'b1;
    in_valid = 4'b1001;
    set_data(0, 16'h0C0C);
    #1;
    check("rr_wrap_ready", 32'(in_ready), 32'b0001);
    tick();
    check_out("rr_wrap", 1'b1, 16'h0C0C, 2'd0);

    // With last=0, RR picks ch3 but fixed priority picks ch0
    #1;
    check("rr_after0_ready", 32'(in_ready), 32'b1000);
    mode = 1'b0;
    #1;
    check("sw_fp_ready", 32'(in_ready), 32'b0001);
    tick();
    check_out("sw_fp", 1'b1, 16'h0C0C, 2'd0);

    // Drain with no input
    in_valid = 4'b0000;
    #1;
    check("idle_ready", 32'(in_ready), 32'h0);
    tick();
    check("drain_valid", 32'(out_valid), 32'h0);

    // Reset while holding a word under backpressure
    mode     = 1'b1;
    in_valid = 4'b0100;
    set_data(2, 16'h5A5A);
    tick();
    check_out("mid_load", 1'b1, 16'h5A5A, 2'd2);
    out_ready = 1'b0;
    rst       = 1'b1;
    #1;
    check("mid_rst_ready", 32'(in_ready), 32'h0);
    tick();
    check_out("mid_rst", 1'b0, 16'h0000, 2'd0);
    rst       = 1'b0;
    out_ready = 1'b1;
    in_valid  = 4'b1111;
    for (int i = 0; i < NCH; i++) set_data(i, 16'hA000 + 16'(i));
    #1;
    check("restart_ready", 32'(in_ready), 32'b0001);
    tick();
    check_out("restart", 1'b1, 16'hA000, 2'd0);
    tick();
    check_out("restart2", 1'b1, 16'hA001, 2'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
